dmem_responder: RTL and testbench

Memory-side responder for the core's data-access port. Accepts one load or store request at a time over a valid/ready handshake and performs it against an internal word-addressed RAM after a programmable number of wait states. Returns a response (read data or store acknowledge, plus an error flag) over a second valid/ready handshake. It sits between the access stage and data storage, so the pipeline can be exercised against non-zero memory latency.

---
 rtl/rv32_mem_pkg.sv | 32 +++
 rtl/dmem_array.sv | 47 ++++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg
// Types and constants shared by the data-memory side of the core: the
// responder FSM states, the byte-enable width, and the memory access-type
// encodings used by the access-stage control and by dmem_responder.
package rv32_mem_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Kind of access carried by a request.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    // Access size as encoded in the load/store funct3 field.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Single-port synchronous word RAM, one read or write per cycle.
// Writes honour per-byte enables; reads land in an output register that
// holds its value until the next read.
// Ports:
//   clk      clock
//   en_i     perform an access this cycle
//   we_i     1 = write, 0 = read
//   addr_i   word index
//   wdata_i  write data
//   be_i     byte enables for writes
//   rdata_o  registered read data
module dmem_array
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [XLEN-1:0] rdata_q;

    // No reset: memory contents survive a block reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side responder for the core data port. Accepts one load/store at
// a time, waits LATENCY cycles, accesses the internal RAM, then presents a
// response until the requester takes it.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | counting down wait states
//   RESP  | response presented, held until rsp_ready
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we, req_addr      store flag, byte address
//   req_wdata, req_be     store data and byte enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load data (0 for stores/errors), error flag
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err
);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    mem_op_e           op_q;
    logic              err_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              accept;
    logic              acc_en;
    logic              sel_live;
    logic              acc_err;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              ram_en;
    logic [31:0]       ram_rdata;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_d = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        acc_en  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    acc_en  = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero latency the access coincides with the accept edge, so the
    // RAM must see the live request rather than the (not yet loaded) latch.
    assign sel_live  = (state_q == IDLE);
    assign acc_err   = sel_live ? addr_err(req_addr) : err_q;
    assign acc_we    = sel_live ? req_we : (op_q == MEM_STORE);
    assign acc_idx   = sel_live ? req_addr[ADDR_W+1:2] : idx_q;
    assign acc_wdata = sel_live ? req_wdata : wdata_q;
    assign acc_be    = sel_live ? req_be : be_q;

    // Reset on the access edge aborts the access; errored requests never
    // touch the RAM.
    assign ram_en = acc_en && !rst && !acc_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= MEM_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= req_we ? MEM_STORE : MEM_LOAD;
                err_q <= addr_err(req_addr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (acc_we),
        .addr_i  (acc_idx),
        .wdata_i (acc_wdata),
        .be_i    (acc_be),
        .rdata_o (ram_rdata)
    );

    // The RAM output register is only refreshed by reads, so it stays
    // stable for the whole RESP phase.
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = ((state_q == RESP) && (op_q == MEM_LOAD) && !err_q)
                       ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst2, rst0;
    logic        v2, v0;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rsp_ready;

    logic        ready2, rv2, err2;
    logic [31:0] rdata2;
    logic        ready0, rv0, err0;
    logic [31:0] rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst2),
        .req_valid(v2), .req_ready(ready2), .req_we(we), .req_addr(addr),
        .req_wdata(wdata), .req_be(be),
        .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rdata2), .rsp_err(err2)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst0),
        .req_valid(v0), .req_ready(ready0), .req_we(we), .req_addr(addr),
        .req_wdata(wdata), .req_be(be),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rdata0), .rsp_err(err0)
    );

    // Called at a negedge. Returns at the negedge of the first cycle with
    // rsp_valid high; lat counts cycles from the accept cycle to that one.
    task automatic send_req(input bit l0, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, output int lat);
        int n;
        we = w; addr = a; wdata = d; be = b;
        if (l0) v0 = 1'b1; else v2 = 1'b1;
        n = 0;
        while (!(l0 ? ready0 : ready2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v2 = 1'b0;
        lat = 1;
        while (!(l0 ? rv0 : rv2) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_xact(input bit l0, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           output logic [31:0] rd, output logic er, output int lat);
        rsp_ready = 1'b1;
        send_req(l0, w, a, d, b, lat);
        rd = l0 ? rdata0 : rdata2;
        er = l0 ? err0 : err2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst0 = 1'b1;
        v2 = 1'b0; v0 = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst2 = 1'b0; rst0 = 1'b0;
        n_checks++;
        if ({ready2, rv2, err2, rdata2} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_l2: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                     ready2, rv2, err2, rdata2);
        end
        n_checks++;
        if ({ready0, rv0, err0, rdata0} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_l0: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                     ready0, rv0, err0, rdata0);
        end
    endtask

    // Directed vectors on the LATENCY=2 instance, in order.
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic test_vectors();
        vec_t v [9];
        logic [31:0] rd;
        logic        er;
        int          lat;
        v[0] = '{1'b1, 32'h10,     32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        v[1] = '{1'b0, 32'h10,     32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        v[2] = '{1'b1, 32'h10,     32'h000000AA, 4'h1, 32'h0,        1'b0};
        v[3] = '{1'b0, 32'h10,     32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        v[4] = '{1'b1, 32'h10,     32'h11111111, 4'h0, 32'h0,        1'b0};
        v[5] = '{1'b0, 32'h12,     32'h0,        4'h0, 32'h0,        1'b1};
        v[6] = '{1'b1, 32'h0,      32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        v[7] = '{1'b1, 32'h1000,   32'h55555555, 4'hF, 32'h0,        1'b1};
        v[8] = '{1'b0, 32'h0,      32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        for (int i = 0; i < 9; i++) begin
            do_xact(1'b0, v[i].w, v[i].a, v[i].d, v[i].b, rd, er, lat);
            n_checks++;
            if (lat !== 3) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d cycles, want 3", i, lat);
            end
            n_checks++;
            if ({er, rd} !== {v[i].exp_err, v[i].exp_rd}) begin
                n_fail++;
                $display("FAIL vec%0d_rsp: err=%b rdata=%h, want err=%b rdata=%h",
                         i, er, rd, v[i].exp_err, v[i].exp_rd);
            end
        end
        // be=0 store must leave the word intact
        do_xact(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'hDEADBEAA}) begin
            n_fail++;
            $display("FAIL be_zero_readback: err=%b rdata=%h, want 0 deadbeaa", er, rd);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        rsp_ready = 1'b0;
        send_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat);
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles, want 3", lat);
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({rv2, ready2, err2, rdata2} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEAA}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b err=%b rdata=%h, want 1 0 0 deadbeaa",
                         c, rv2, ready2, err2, rdata2);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rv2, ready2} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b, want 0 1", rv2, ready2);
        end
    endtask

    task automatic test_latency0();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc [$];
        do_xact(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        do_xact(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL l0_latency: got %0d cycles, want 1", lat);
        end
        n_checks++;
        if ({er, rd} !== {1'b0, 32'hA5A5A5A5}) begin
            n_fail++;
            $display("FAIL l0_load: err=%b rdata=%h, want 0 a5a5a5a5", er, rd);
        end
        do_xact(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'h0, rd, er, lat);
        n_checks++;
        if ({er, rd, lat} !== {1'b1, 32'h0, 32'd1}) begin
            n_fail++;
            $display("FAIL l0_range_err: err=%b rdata=%h lat=%0d, want 1 00000000 1", er, rd, lat);
        end
        // Streaming loads with rsp_ready held high
        we = 1'b0; addr = 32'h8; be = 4'h0; rsp_ready = 1'b1; v0 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ready0) acc.push_back(c);
            n_checks++;
            if (rv0 !== c[0]) begin
                n_fail++;
                $display("FAIL l0_stream_valid%0d: valid=%b, want %b", c, rv0, c[0]);
            end
            @(negedge clk);
        end
        v0 = 1'b0;
        n_checks++;
        if (acc.size() != 5) begin
            n_fail++;
            $display("FAIL l0_accept_count: got %0d, want 5", acc.size());
        end else begin
            for (int k = 1; k < 5; k++) begin
                n_checks++;
                if (acc[k] - acc[k-1] != 2) begin
                    n_fail++;
                    $display("FAIL l0_accept_gap%0d: got %0d, want 2", k, acc[k] - acc[k-1]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_xact(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF; v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        rst2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        n_checks++;
        if ({ready2, rv2} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_wait_state: ready=%b valid=%b, want 1 0", ready2, rv2);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rv2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_no_rsp: valid=%b, want 0", rv2);
        end
        do_xact(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h11223344}) begin
            n_fail++;
            $display("FAIL rst_wait_readback: err=%b rdata=%h, want 0 11223344", er, rd);
        end
    endtask

    initial begin
        rst2 = 1'b1; rst0 = 1'b1;
        v2 = 1'b0; v0 = 1'b0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_latency0();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
